// File: rtl/hazard_unit_if.sv
// Decode-to-hazard-unit bundle: ID-stage operand/decode info in, pipeline control out.
// HAZARD_STATS_EN adds the stall/flush statistics counters to the bundle.
interface hazard_unit_if #(
  parameter int REG_AW = 5
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W = 32
`endif
);
  logic              mem_stall;
  logic [REG_AW-1:0] rs1_id;
  logic [REG_AW-1:0] rs2_id;
  logic [REG_AW-1:0] rd_id;
  logic              rs1use_id;
  logic              rs2use_id;
  logic [1:0]        hazard_optype_id;
  logic              Branch_id;

  logic              PC_EN_IF;
  logic              reg_FD_EN;
  logic              reg_FD_flush;
  logic              reg_DE_flush;
  logic [1:0]        forward_ctrl_A;
  logic [1:0]        forward_ctrl_B;
  logic              forward_ctrl_ls;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  modport master (
    output mem_stall, rs1_id, rs2_id, rd_id, rs1use_id, rs2use_id, hazard_optype_id, Branch_id,
    input  PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
    input  forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls
`ifdef HAZARD_STATS_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  mem_stall, rs1_id, rs2_id, rd_id, rs1use_id, rs2use_id, hazard_optype_id, Branch_id,
    output PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
    output forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls
`ifdef HAZARD_STATS_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/hazard_unit.sv
// Stall/flush/forward control for the 5-stage RV32I core, built on a private EX/MEM shadow
// scoreboard. Define HAZARD_STATS_EN to add saturating stall and flush counters.
module hazard_unit #(
  parameter int REG_AW = 5
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_unit_if.slave hz
);

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_ALU   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_EX_ALU  = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;

  typedef struct packed {
    logic [1:0]        op;
    logic [REG_AW-1:0] rd;
    logic              ls;
  } shadow_t;

  localparam shadow_t BUBBLE = '{op: OP_NONE, rd: '0, ls: 1'b0};

  shadow_t ex_q, ex_d;
  shadow_t mem_q, mem_d;

  logic       ld_hit1_s, ld_hit2_s;
  logic       store_bypass_s;
  logic       stall_s;
  logic [1:0] fwd_a_s, fwd_b_s;

  // x0 is never a real dependency, and stores/bubbles never produce a value
  function automatic logic src_match(input logic use_s, input logic [REG_AW-1:0] rs,
                                     input shadow_t stg);
    logic writer_s;
    case (stg.op)
      OP_ALU, OP_LOAD: writer_s = 1'b1;
      OP_NONE, OP_STORE: writer_s = 1'b0;
      default: writer_s = 1'b0;
    endcase
    return use_s && writer_s && (stg.rd == rs) && (rs != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic use_s, input logic [REG_AW-1:0] rs,
                                         input shadow_t ex_s, input shadow_t mem_s);
    logic [1:0] sel_s;
    sel_s = FWD_RF;
    if (src_match(use_s, rs, ex_s) && (ex_s.op == OP_ALU)) begin
      sel_s = FWD_EX_ALU;
    end else if (src_match(use_s, rs, mem_s)) begin
      case (mem_s.op)
        OP_ALU:  sel_s = FWD_MEM_ALU;
        OP_LOAD: sel_s = FWD_MEM_LD;
        default: sel_s = FWD_RF;
      endcase
    end else begin
      sel_s = FWD_RF;
    end
    return sel_s;
  endfunction

  // Load-use detection; store data may instead be patched later from WB load data
  always_comb begin
    ld_hit1_s = src_match(hz.rs1use_id, hz.rs1_id, ex_q) && (ex_q.op == OP_LOAD);
    ld_hit2_s = src_match(hz.rs2use_id, hz.rs2_id, ex_q) && (ex_q.op == OP_LOAD);
    store_bypass_s = (hz.hazard_optype_id == OP_STORE) && ld_hit2_s && !ld_hit1_s;
    stall_s = (ld_hit1_s || ld_hit2_s) && !store_bypass_s;
    fwd_a_s = fwd_sel(hz.rs1use_id, hz.rs1_id, ex_q, mem_q);
    fwd_b_s = fwd_sel(hz.rs2use_id, hz.rs2_id, ex_q, mem_q);
  end

  // Pipeline enables and flushes; a memory stall freezes everything and wins
  always_comb begin
    hz.PC_EN_IF     = 1'b1;
    hz.reg_FD_EN    = 1'b1;
    hz.reg_FD_flush = 1'b0;
    hz.reg_DE_flush = 1'b0;
    if (hz.mem_stall) begin
      hz.PC_EN_IF  = 1'b0;
      hz.reg_FD_EN = 1'b0;
    end else if (stall_s) begin
      hz.PC_EN_IF     = 1'b0;
      hz.reg_FD_EN    = 1'b0;
      hz.reg_DE_flush = 1'b1;
    end else if (hz.Branch_id) begin
      hz.reg_FD_flush = 1'b1;
    end else begin
      hz.reg_FD_flush = 1'b0;
    end
  end

  // Forward selects
  always_comb begin
    hz.forward_ctrl_A  = fwd_a_s;
    hz.forward_ctrl_B  = fwd_b_s;
    hz.forward_ctrl_ls = mem_q.ls;
  end

  // Shadow scoreboard next state
  always_comb begin
    mem_d = mem_q;
    ex_d  = ex_q;
    if (!hz.mem_stall) begin
      mem_d = ex_q;
      if (stall_s) begin
        ex_d = BUBBLE;
      end else begin
        ex_d = '{op: hz.hazard_optype_id, rd: hz.rd_id, ls: store_bypass_s};
      end
    end else begin
      mem_d = mem_q;
      ex_d  = ex_q;
    end
  end

  // Shadow scoreboard registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters, counted only in cycles the pipeline advances
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hz.mem_stall && stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (hz.reg_FD_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against an in-flight-instruction model.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_unit_if #(.REG_AW(5)) hz ();

  hazard_unit #(.REG_AW(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // One in-flight instruction as the model sees it
  typedef struct packed {
    logic       wr;
    logic       ld;
    logic       ls;
    logic [4:0] rd;
  } inst_t;

  typedef struct packed {
    logic       pc;
    logic       fden;
    logic       fdfl;
    logic       deflush;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       fls;
    logic       stall;
    logic       ls_new;
    logic       dca;
    logic       dcb;
  } exp_t;

  inst_t ex_m, mem_m;
  exp_t  e_now;
  int    stall_cnt_m, flush_cnt_m;

  function automatic logic [1:0] pick(inst_t ex, inst_t mem, logic [4:0] rs, logic u);
    if (!u || rs == 5'd0) return 2'd0;
    if (ex.wr && !ex.ld && ex.rd == rs) return 2'd1;
    if (mem.wr && mem.rd == rs) return mem.ld ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  function automatic exp_t model_out(inst_t ex, inst_t mem, logic ms,
                                     logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                                     logic [1:0] op, logic br);
    exp_t e;
    logic h1, h2;
    e  = '0;
    h1 = u1 && rs1 != 5'd0 && ex.wr && ex.ld && ex.rd == rs1;
    h2 = u2 && rs2 != 5'd0 && ex.wr && ex.ld && ex.rd == rs2;
    e.ls_new  = (op == 2'b11) && h2 && !h1;
    e.stall   = (h1 || h2) && !e.ls_new;
    e.pc      = !ms && !e.stall;
    e.fden    = !ms && !e.stall;
    e.deflush = !ms && e.stall;
    e.fdfl    = !ms && !e.stall && br;
    e.fa      = pick(ex, mem, rs1, u1);
    e.fb      = pick(ex, mem, rs2, u2);
    e.fls     = mem.ls;
    e.dca     = e.stall && h1;
    e.dcb     = e.stall && h2;
    return e;
  endfunction

  assign e_now = model_out(ex_m, mem_m, hz.mem_stall, hz.rs1_id, hz.rs1use_id,
                           hz.rs2_id, hz.rs2use_id, hz.hazard_optype_id, hz.Branch_id);

  // Model advance: instructions age from ID into EX and MEM unless memory stalls
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_m        <= '0;
      mem_m       <= '0;
      stall_cnt_m <= 0;
      flush_cnt_m <= 0;
    end else if (!hz.mem_stall) begin
      mem_m <= ex_m;
      if (e_now.stall) ex_m <= '0;
      else ex_m <= '{wr: (hz.hazard_optype_id == 2'b01 || hz.hazard_optype_id == 2'b10),
                     ld: (hz.hazard_optype_id == 2'b10), ls: e_now.ls_new, rd: hz.rd_id};
      stall_cnt_m <= stall_cnt_m + (e_now.stall ? 1 : 0);
      flush_cnt_m <= flush_cnt_m + (e_now.fdfl ? 1 : 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("PC_EN_IF", 32'(hz.PC_EN_IF), 32'(e_now.pc));
    chk("reg_FD_EN", 32'(hz.reg_FD_EN), 32'(e_now.fden));
    chk("reg_FD_flush", 32'(hz.reg_FD_flush), 32'(e_now.fdfl));
    chk("reg_DE_flush", 32'(hz.reg_DE_flush), 32'(e_now.deflush));
    chk("forward_ctrl_ls", 32'(hz.forward_ctrl_ls), 32'(e_now.fls));
    if (!e_now.dca) chk("forward_ctrl_A", 32'(hz.forward_ctrl_A), 32'(e_now.fa));
    if (!e_now.dcb) chk("forward_ctrl_B", 32'(hz.forward_ctrl_B), 32'(e_now.fb));
`ifdef HAZARD_STATS_EN
    chk("stall_cnt", 32'(hz.stall_cnt), 32'(stall_cnt_m));
    chk("flush_cnt", 32'(hz.flush_cnt), 32'(flush_cnt_m));
`endif
  end

  task automatic id(input int r1, input int u1, input int r2, input int u2,
                    input int rd, input int op, input int br);
    hz.rs1_id           = 5'(r1);
    hz.rs1use_id        = 1'(u1);
    hz.rs2_id           = 5'(r2);
    hz.rs2use_id        = 1'(u2);
    hz.rd_id            = 5'(rd);
    hz.hazard_optype_id = 2'(op);
    hz.Branch_id        = 1'(br);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    hz.mem_stall = 1'b0;
    id(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    at_neg();
    chk("reset PC_EN_IF", 32'(hz.PC_EN_IF), 32'd1);
    chk("reset reg_FD_EN", 32'(hz.reg_FD_EN), 32'd1);
    chk("reset reg_DE_flush", 32'(hz.reg_DE_flush), 32'd0);
    chk("reset forward_ctrl_A", 32'(hz.forward_ctrl_A), 32'd0);

    // 1: ALU result forwarded from EX, then from MEM
    tick(); id(0, 0, 0, 0, 5, 1, 0);
    tick(); id(5, 1, 0, 0, 9, 1, 0);
    at_neg();
    chk("c1 A from EX", 32'(hz.forward_ctrl_A), 32'd1);
    chk("c1 no stall", 32'(hz.PC_EN_IF), 32'd1);
    tick(); id(5, 1, 0, 0, 0, 0, 0);
    at_neg();
    chk("c1 A from MEM", 32'(hz.forward_ctrl_A), 32'd2);

    // 2: load-use costs one bubble, then load data forwarded
    tick(); id(0, 0, 0, 0, 6, 2, 0);
    tick(); id(0, 0, 6, 1, 10, 1, 0);
    at_neg();
    chk("c2 PC_EN_IF stall", 32'(hz.PC_EN_IF), 32'd0);
    chk("c2 DE_flush stall", 32'(hz.reg_DE_flush), 32'd1);
    tick();
    at_neg();
    chk("c2 B from load", 32'(hz.forward_ctrl_B), 32'd3);
    chk("c2 resumed", 32'(hz.PC_EN_IF), 32'd1);

    // 3: store data after load: no stall, ls flag reaches MEM two cycles later
    tick(); id(0, 0, 0, 0, 7, 2, 0);
    tick(); id(2, 1, 7, 1, 0, 3, 0);
    at_neg();
    chk("c3 store no stall", 32'(hz.PC_EN_IF), 32'd1);
    tick(); id(0, 0, 0, 0, 0, 0, 0);
    at_neg();
    chk("c3 ls early", 32'(hz.forward_ctrl_ls), 32'd0);
    tick();
    at_neg();
    chk("c3 ls set", 32'(hz.forward_ctrl_ls), 32'd1);
    tick();
    at_neg();
    chk("c3 ls cleared", 32'(hz.forward_ctrl_ls), 32'd0);

    // 4: branch on load result waits one cycle before flushing
    tick(); id(0, 0, 0, 0, 8, 2, 0);
    tick(); id(8, 1, 0, 0, 0, 0, 1);
    at_neg();
    chk("c4 no flush in stall", 32'(hz.reg_FD_flush), 32'd0);
    tick();
    at_neg();
    chk("c4 flush after stall", 32'(hz.reg_FD_flush), 32'd1);
    chk("c4 A from load", 32'(hz.forward_ctrl_A), 32'd3);

    // 5: x0 never forwards; memory stall freezes a pending load-use
    tick(); id(0, 0, 0, 0, 0, 1, 0);
    tick(); id(0, 1, 0, 0, 0, 0, 0);
    at_neg();
    chk("c5 x0 A", 32'(hz.forward_ctrl_A), 32'd0);
    tick(); id(0, 0, 0, 0, 6, 2, 0);
    tick(); id(0, 0, 6, 1, 10, 1, 0); hz.mem_stall = 1'b1;
    at_neg();
    chk("c5 memstall DE_flush", 32'(hz.reg_DE_flush), 32'd0);
    chk("c5 memstall FD_EN", 32'(hz.reg_FD_EN), 32'd0);
    tick(); hz.mem_stall = 1'b0;
    at_neg();
    chk("c5 stall after freeze", 32'(hz.reg_DE_flush), 32'd1);
    tick();
    at_neg();
    chk("c5 B after freeze", 32'(hz.forward_ctrl_B), 32'd3);

    // 6: async reset during a load-use stall
    tick(); id(0, 0, 0, 0, 6, 2, 0);
    tick(); id(0, 0, 6, 1, 10, 1, 0);
    at_neg();
    chk("c6 stall before reset", 32'(hz.reg_DE_flush), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("c6 reset PC_EN_IF", 32'(hz.PC_EN_IF), 32'd1);
    chk("c6 reset DE_flush", 32'(hz.reg_DE_flush), 32'd0);
    chk("c6 reset FD_EN", 32'(hz.reg_FD_EN), 32'd1);
    tick(); rst_n = 1'b1;
`ifdef HAZARD_STATS_EN
    id(0, 0, 0, 0, 6, 2, 0);
    tick(); id(0, 0, 6, 1, 10, 1, 0);
    tick(); id(0, 0, 0, 0, 0, 0, 0);
    at_neg();
    chk("c6 stall_cnt one", 32'(hz.stall_cnt), 32'd1);
    chk("c6 flush_cnt zero", 32'(hz.flush_cnt), 32'd0);
`endif

    // Randomized traffic over a small register window to provoke dependencies
    for (int i = 0; i < 3000; i++) begin
      tick();
      id($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
         $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
         ($urandom_range(0, 3) == 0) ? 1 : 0);
      hz.mem_stall = ($urandom_range(0, 7) == 0);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
    end
    tick();
    rst_n = 1'b1;
    at_neg();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
